// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequencer in front of the shared 8-bit ALU.
// A request is latched in IDLE and sent through the ALU in EXEC. Decimal
// ADC/SBC make a second pass in ADJ that applies the BCD nibble correction
// through the same adder. Result and flags are registered and held until
// the next done pulse.
module alu_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] req_op,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   input  logic       req_ci,
   input  logic       req_sub,
   input  logic       req_dec,
   output logic [7:0] alu_ai,
   output logic [7:0] alu_bi,
   output logic       alu_ci,
   output logic [2:0] alu_op,
   input  logic [7:0] alu_out,
   input  logic       alu_c,
   input  logic       alu_v,
   input  logic       alu_dc,
   input  logic       alu_dhc,
   output logic       busy,
   output logic       done,
   output logic [7:0] result,
   output logic       c_out,
   output logic       n_out,
   output logic       z_out,
   output logic       v_out
);

   // Shared ALU op encoding: AI=0, ADC=1, ROL=2, ROR=3, ORA=4, EOR=5, AND=6.
   // Only ADC needs to be recognised here; every other op passes through.
   localparam logic [2:0] ALU_ADC = 3'd1;

   typedef enum logic [1:0] {IDLE, EXEC, ADJ, DONE} state_t;

   state_t     state;

   // Latched request
   logic [2:0] op_q;
   logic [7:0] a_q;
   logic [7:0] b_q;
   logic       ci_q;
   logic       sub_q;
   logic       dec_q;

   // First-pass results kept for the decimal correction pass
   logic [7:0] s1;
   logic       c1;
   logic       v1;
   logic       dc1;
   logic       dhc1;
   logic       hc1;

   logic       hc_bin;
   logic [7:0] adj_add;
   logic [7:0] adj_sub;

   // Decimal add correction: +6 on each digit that overflowed past 9.
   function automatic logic [7:0] bcd_add_fix(input logic hi, input logic lo);
      return {hi ? 4'h6 : 4'h0, lo ? 4'h6 : 4'h0};
   endfunction

   // Decimal subtract correction: -6 on each digit that borrowed.
   function automatic logic [7:0] bcd_sub_fix(input logic hi_c, input logic lo_c);
      return {hi_c ? 4'h0 : 4'h6, lo_c ? 4'h0 : 4'h6};
   endfunction

   assign adj_add = bcd_add_fix(dc1 | c1, dhc1 | hc1);
   assign adj_sub = bcd_sub_fix(c1, hc1);

   // Carry into bit 4 of the binary sum; only meaningful while in EXEC.
   assign hc_bin = alu_out[4] ^ alu_ai[4] ^ alu_bi[4];

   // ALU drive: latched request, except the correction pass in ADJ.
   always_comb begin
      alu_op = op_q;
      alu_ai = a_q;
      alu_bi = sub_q ? ~b_q : b_q;
      alu_ci = ci_q;
      if (state == ADJ) begin
         alu_op = ALU_ADC;
         alu_ai = s1;
         if (sub_q) begin
            alu_bi = ~adj_sub;
            alu_ci = 1'b1;
         end else begin
            alu_bi = adj_add;
            alu_ci = 1'b0;
         end
      end
   end

   // Sequencer state, request latch, pass registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_q   <= 3'd0;
         a_q    <= 8'h00;
         b_q    <= 8'h00;
         ci_q   <= 1'b0;
         sub_q  <= 1'b0;
         dec_q  <= 1'b0;
         s1     <= 8'h00;
         c1     <= 1'b0;
         v1     <= 1'b0;
         dc1    <= 1'b0;
         dhc1   <= 1'b0;
         hc1    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= 8'h00;
         c_out  <= 1'b0;
         n_out  <= 1'b0;
         z_out  <= 1'b0;
         v_out  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= req_op;
                  a_q   <= req_a;
                  b_q   <= req_b;
                  ci_q  <= req_ci;
                  sub_q <= req_sub;
                  dec_q <= req_dec;
                  busy  <= 1'b1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               s1   <= alu_out;
               c1   <= alu_c;
               v1   <= alu_v;
               dc1  <= alu_dc;
               dhc1 <= alu_dhc;
               hc1  <= hc_bin;
               if (op_q == ALU_ADC && dec_q) begin
                  state <= ADJ;
               end else begin
                  result <= alu_out;
                  c_out  <= alu_c;
                  v_out  <= alu_v;
                  n_out  <= alu_out[7];
                  z_out  <= (alu_out == 8'h00);
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            ADJ: begin
               // Add keeps any decimal carry from the first pass; subtract
               // reports the binary borrow of the first pass.
               result <= alu_out;
               c_out  <= sub_q ? c1 : (c1 | dc1);
               v_out  <= v1;
               n_out  <= alu_out[7];
               z_out  <= (alu_out == 8'h00);
               busy   <= 1'b0;
               done   <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               // A start seen here is dropped; acceptance resumes in IDLE.
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
